// File: rtl/radar_signal_gen.sv
// Radar timing triplet generator: TRIG, ACP and ARP pulse trains derived from
// cycle-count configuration, with start/stop only on whole revolutions.
// Optional feature: define RADAR_GEN_REV_CNT_EN to add the REV_CNT output, a
// free-running count of completed revolutions.
module radar_signal_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PULSE_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] TRIG_PERIOD,
  input  logic [DATA_WIDTH-1:0] TRIG_PER_ACP,
  input  logic [DATA_WIDTH-1:0] ACP_PER_ARP,
  input  logic [PULSE_BITS-1:0] PULSE_LEN,
  output logic                  TRIG,
  output logic                  ACP,
  output logic                  ARP,
  output logic                  RUNNING,
  output logic [DATA_WIDTH-1:0] TRIG_IDX,
  output logic [DATA_WIDTH-1:0] ACP_IDX,
`ifdef RADAR_GEN_REV_CNT_EN
  output logic [DATA_WIDTH-1:0] REV_CNT,
`endif
  output logic                  CFG_ERR
);

  localparam logic [DATA_WIDTH-1:0] DOne = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DTwo = DATA_WIDTH'(2);
  localparam logic [PULSE_BITS-1:0] POne = PULSE_BITS'(1);

  // StStart is the one-cycle gap between accepting a start and the first
  // coincident TRIG/ACP/ARP edge.
  typedef enum logic [1:0] {StIdle, StStart, StRun} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] per_q, tpa_q, apa_q;
  logic [PULSE_BITS-1:0] plen_q;
  logic [DATA_WIDTH-1:0] pcnt_q, tidx_q, aidx_q;
  logic [PULSE_BITS-1:0] hcnt_q;
  logic                  trig_q, acp_q, arp_q, running_q, cfg_err_q;
`ifdef RADAR_GEN_REV_CNT_EN
  logic [DATA_WIDTH-1:0] rev_cnt_q;
`endif

  logic [DATA_WIDTH-1:0] plen_ext;
  logic                  cfg_valid;
  logic                  pcnt_wrap, tidx_wrap, aidx_wrap;
  logic [DATA_WIDTH-1:0] pcnt_d, tidx_d, aidx_d;

  // Config check on the live ports and next position within the revolution.
  always_comb begin
    plen_ext  = DATA_WIDTH'(PULSE_LEN);
    cfg_valid = (TRIG_PERIOD >= DTwo) && (TRIG_PER_ACP != '0) && (ACP_PER_ARP != '0) &&
                (plen_ext != '0) && (plen_ext < TRIG_PERIOD);
    // Latched counts are always >= 1 here, so count-1 cannot underflow.
    pcnt_wrap = (pcnt_q == per_q - DOne);
    tidx_wrap = pcnt_wrap && (tidx_q == tpa_q - DOne);
    aidx_wrap = tidx_wrap && (aidx_q == apa_q - DOne);
    pcnt_d    = pcnt_wrap ? '0 : pcnt_q + DOne;
    tidx_d    = tidx_q;
    aidx_d    = aidx_q;
    if (pcnt_wrap) tidx_d = tidx_wrap ? '0 : tidx_q + DOne;
    if (tidx_wrap) aidx_d = aidx_wrap ? '0 : aidx_q + DOne;
  end

  // Control FSM, position counters and registered pulse outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      per_q     <= '0;
      tpa_q     <= '0;
      apa_q     <= '0;
      plen_q    <= '0;
      pcnt_q    <= '0;
      tidx_q    <= '0;
      aidx_q    <= '0;
      hcnt_q    <= '0;
      trig_q    <= 1'b0;
      acp_q     <= 1'b0;
      arp_q     <= 1'b0;
      running_q <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef RADAR_GEN_REV_CNT_EN
      rev_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (EN) begin
            if (cfg_valid) begin
              per_q     <= TRIG_PERIOD;
              tpa_q     <= TRIG_PER_ACP;
              apa_q     <= ACP_PER_ARP;
              plen_q    <= PULSE_LEN;
              cfg_err_q <= 1'b0;
              state_q   <= StStart;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StStart: begin
          state_q   <= StRun;
          running_q <= 1'b1;
          pcnt_q    <= '0;
          tidx_q    <= '0;
          aidx_q    <= '0;
          trig_q    <= 1'b1;
          acp_q     <= 1'b1;
          arp_q     <= 1'b1;
          hcnt_q    <= POne;
        end
        StRun: begin
          if (aidx_wrap && (!EN || !cfg_valid)) begin
            // Revolution boundary without permission to continue: the ARP
            // that would start here is suppressed.
            state_q   <= StIdle;
            running_q <= 1'b0;
            pcnt_q    <= '0;
            tidx_q    <= '0;
            aidx_q    <= '0;
            hcnt_q    <= '0;
            trig_q    <= 1'b0;
            acp_q     <= 1'b0;
            arp_q     <= 1'b0;
            if (EN) cfg_err_q <= 1'b1;
`ifdef RADAR_GEN_REV_CNT_EN
            rev_cnt_q <= rev_cnt_q + DOne;
`endif
          end else begin
            pcnt_q <= pcnt_d;
            tidx_q <= tidx_d;
            aidx_q <= aidx_d;
            if (pcnt_wrap) begin
              trig_q <= 1'b1;
              acp_q  <= tidx_wrap;
              arp_q  <= aidx_wrap;
              hcnt_q <= POne;
              if (aidx_wrap) begin
                // New config takes effect from this ARP onwards.
                per_q  <= TRIG_PERIOD;
                tpa_q  <= TRIG_PER_ACP;
                apa_q  <= ACP_PER_ARP;
                plen_q <= PULSE_LEN;
`ifdef RADAR_GEN_REV_CNT_EN
                rev_cnt_q <= rev_cnt_q + DOne;
`endif
              end
            end else if (hcnt_q == plen_q) begin
              // PULSE_LEN < TRIG_PERIOD guarantees the pulse ends before the
              // next trigger start.
              trig_q <= 1'b0;
              acp_q  <= 1'b0;
              arp_q  <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q + POne;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TRIG     = trig_q;
  assign ACP      = acp_q;
  assign ARP      = arp_q;
  assign RUNNING  = running_q;
  assign TRIG_IDX = tidx_q;
  assign ACP_IDX  = aidx_q;
  assign CFG_ERR  = cfg_err_q;
`ifdef RADAR_GEN_REV_CNT_EN
  assign REV_CNT  = rev_cnt_q;
`endif

endmodule

// File: tb/tb_radar_signal_gen.sv
// Directed self-checking bench for radar_signal_gen.
module tb_radar_signal_gen;
  localparam int DW = 32;
  localparam int PB = 8;

  logic          CLK = 1'b0;
  logic          RST, EN;
  logic [DW-1:0] TRIG_PERIOD, TRIG_PER_ACP, ACP_PER_ARP;
  logic [PB-1:0] PULSE_LEN;
  logic          TRIG, ACP, ARP, RUNNING, CFG_ERR;
  logic [DW-1:0] TRIG_IDX, ACP_IDX;
`ifdef RADAR_GEN_REV_CNT_EN
  logic [DW-1:0] REV_CNT;
`endif

  int checks = 0;
  int errors = 0;

  radar_signal_gen #(.DATA_WIDTH(DW), .PULSE_BITS(PB)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .TRIG_PERIOD  (TRIG_PERIOD),
    .TRIG_PER_ACP (TRIG_PER_ACP),
    .ACP_PER_ARP  (ACP_PER_ARP),
    .PULSE_LEN    (PULSE_LEN),
    .TRIG         (TRIG),
    .ACP          (ACP),
    .ARP          (ARP),
    .RUNNING      (RUNNING),
    .TRIG_IDX     (TRIG_IDX),
    .ACP_IDX      (ACP_IDX),
`ifdef RADAR_GEN_REV_CNT_EN
    .REV_CNT      (REV_CNT),
`endif
    .CFG_ERR      (CFG_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected {TRIG,ACP,ARP} at cycle c after the first ARP edge of a revolution.
  function automatic logic [2:0] exp_pulse(int c, int per, int tpa, int apa, int pl);
    int  p = c % per;
    int  t = (c / per) % tpa;
    int  a = (c / (per * tpa)) % apa;
    logic tr = (p < pl);
    return {tr, tr && (t == 0), tr && (t == 0) && (a == 0)};
  endfunction

  function automatic int exp_tidx(int c, int per, int tpa);
    return (c / per) % tpa;
  endfunction

  function automatic int exp_aidx(int c, int per, int tpa, int apa);
    return (c / (per * tpa)) % apa;
  endfunction

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0;
    TRIG_PERIOD = 10; TRIG_PER_ACP = 4; ACP_PER_ARP = 3; PULSE_LEN = 0;
    tick(); tick();
    RST = 1'b0; EN = 1'b1;  // invalid config: PULSE_LEN=0
    tick();
    checks++;
    if (CFG_ERR !== 1'b1) begin
      errors++; $display("FAIL reset_pre_err: CFG_ERR got %b expected 1", CFG_ERR);
    end
    RST = 1'b1;
    tick();
    checks++;
    if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {TRIG, ACP, ARP, RUNNING, CFG_ERR});
    end
    checks++;
    if (TRIG_IDX !== '0 || ACP_IDX !== '0) begin
      errors++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", TRIG_IDX, ACP_IDX);
    end
`ifdef RADAR_GEN_REV_CNT_EN
    checks++;
    if (REV_CNT !== '0) begin
      errors++; $display("FAIL reset_rev_cnt: got %0d expected 0", REV_CNT);
    end
`endif
    RST = 1'b0; EN = 1'b0; PULSE_LEN = 2;
    tick();
  endtask

  task automatic test_basic_start();
    EN = 1'b1;
    tick();  // edge k
    checks++;
    if ({TRIG, ACP, ARP} !== 3'b000) begin
      errors++; $display("FAIL start_edge_k: pulses got %b expected 000", {TRIG, ACP, ARP});
    end
    for (int c = 0; c < 240; c++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING} !== {exp_pulse(c, 10, 4, 3, 2), 1'b1}) begin
        errors++;
        $display("FAIL basic_pulses c=%0d: got %b expected %b", c, {TRIG, ACP, ARP, RUNNING},
                 {exp_pulse(c, 10, 4, 3, 2), 1'b1});
      end
      checks++;
      if (TRIG_IDX !== DW'(exp_tidx(c, 10, 4)) || ACP_IDX !== DW'(exp_aidx(c, 10, 4, 3))) begin
        errors++;
        $display("FAIL basic_idx c=%0d: got %0d/%0d expected %0d/%0d", c, TRIG_IDX, ACP_IDX,
                 exp_tidx(c, 10, 4), exp_aidx(c, 10, 4, 3));
      end
`ifdef RADAR_GEN_REV_CNT_EN
      if (c == 120) begin
        checks++;
        if (REV_CNT !== DW'(1)) begin
          errors++; $display("FAIL basic_rev_cnt: got %0d expected 1", REV_CNT);
        end
      end
`endif
    end
  endtask

  task automatic test_stop_at_boundary();
    // Continues the run above; revolution cycle r = c - 240.
    for (int c = 240; c < 360; c++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING} !== {exp_pulse(c, 10, 4, 3, 2), 1'b1}) begin
        errors++;
        $display("FAIL stop_pulses c=%0d: got %b expected %b", c, {TRIG, ACP, ARP, RUNNING},
                 {exp_pulse(c, 10, 4, 3, 2), 1'b1});
      end
      if (c == 295) EN = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING} !== 4'b0000 || TRIG_IDX !== '0 || ACP_IDX !== '0) begin
        errors++;
        $display("FAIL stop_idle i=%0d: got %b idx %0d/%0d expected 0000 idx 0/0", i,
                 {TRIG, ACP, ARP, RUNNING}, TRIG_IDX, ACP_IDX);
      end
`ifdef RADAR_GEN_REV_CNT_EN
      checks++;
      if (REV_CNT !== DW'(3)) begin
        errors++; $display("FAIL stop_rev_cnt: got %0d expected 3", REV_CNT);
      end
`endif
    end
  endtask

  task automatic test_invalid_config();
    PULSE_LEN = 10; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b00001) begin
        errors++;
        $display("FAIL invalid_idle i=%0d: got %b expected 00001", i,
                 {TRIG, ACP, ARP, RUNNING, CFG_ERR});
      end
    end
    PULSE_LEN = 3;
    tick();  // edge k
    checks++;
    if (CFG_ERR !== 1'b0) begin
      errors++; $display("FAIL invalid_err_clear: CFG_ERR got %b expected 0", CFG_ERR);
    end
    for (int c = 0; c < 120; c++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING} !== {exp_pulse(c, 10, 4, 3, 3), 1'b1}) begin
        errors++;
        $display("FAIL invalid_restart c=%0d: got %b expected %b", c, {TRIG, ACP, ARP, RUNNING},
                 {exp_pulse(c, 10, 4, 3, 3), 1'b1});
      end
      if (c == 0) EN = 1'b0;
    end
    tick();
    checks++;
    if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b00000) begin
      errors++;
      $display("FAIL invalid_stop: got %b expected 00000", {TRIG, ACP, ARP, RUNNING, CFG_ERR});
    end
`ifdef RADAR_GEN_REV_CNT_EN
    checks++;
    if (REV_CNT !== DW'(4)) begin
      errors++; $display("FAIL invalid_rev_cnt: got %0d expected 4", REV_CNT);
    end
`endif
  endtask

  task automatic test_relatch();
    logic [2:0] ep;
    int         et, ea;
    PULSE_LEN = 2; ACP_PER_ARP = 3; EN = 1'b1;
    tick();  // edge k
    for (int c = 0; c < 520; c++) begin
      tick();
      if (c < 120) begin
        ep = exp_pulse(c, 10, 4, 3, 2); et = exp_tidx(c, 10, 4); ea = exp_aidx(c, 10, 4, 3);
      end else begin
        ep = exp_pulse(c - 120, 10, 4, 5, 2);
        et = exp_tidx(c - 120, 10, 4);
        ea = exp_aidx(c - 120, 10, 4, 5);
      end
      checks++;
      if ({TRIG, ACP, ARP} !== ep) begin
        errors++;
        $display("FAIL relatch_pulses c=%0d: got %b expected %b", c, {TRIG, ACP, ARP}, ep);
      end
      checks++;
      if (TRIG_IDX !== DW'(et) || ACP_IDX !== DW'(ea)) begin
        errors++;
        $display("FAIL relatch_idx c=%0d: got %0d/%0d expected %0d/%0d", c, TRIG_IDX, ACP_IDX,
                 et, ea);
      end
      if (c == 50) ACP_PER_ARP = 5;
      if (c == 330) PULSE_LEN = 0;  // invalid, ignored until the next boundary
    end
    tick();  // boundary with invalid config
    checks++;
    if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b00001) begin
      errors++;
      $display("FAIL relatch_bad_boundary: got %b expected 00001",
               {TRIG, ACP, ARP, RUNNING, CFG_ERR});
    end
`ifdef RADAR_GEN_REV_CNT_EN
    checks++;
    if (REV_CNT !== DW'(7)) begin
      errors++; $display("FAIL relatch_rev_cnt: got %0d expected 7", REV_CNT);
    end
`endif
  endtask

  task automatic test_reset_mid_pulse();
    ACP_PER_ARP = 3; PULSE_LEN = 2; EN = 1'b1;
    tick();  // edge k
    tick();  // ARP cycle 1
    tick();  // ARP cycle 2
    checks++;
    if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b11110) begin
      errors++;
      $display("FAIL rst_pre: got %b expected 11110", {TRIG, ACP, ARP, RUNNING, CFG_ERR});
    end
    RST = 1'b1;
    tick();
    checks++;
    if ({TRIG, ACP, ARP, RUNNING, CFG_ERR} !== 5'b00000 || TRIG_IDX !== '0 || ACP_IDX !== '0)
    begin
      errors++;
      $display("FAIL rst_mid_pulse: got %b idx %0d/%0d expected 00000 idx 0/0",
               {TRIG, ACP, ARP, RUNNING, CFG_ERR}, TRIG_IDX, ACP_IDX);
    end
    RST = 1'b0;
    tick();  // edge k of the restart
    checks++;
    if ({TRIG, ACP, ARP} !== 3'b000) begin
      errors++; $display("FAIL rst_restart_k: got %b expected 000", {TRIG, ACP, ARP});
    end
    for (int c = 0; c < 46; c++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP, RUNNING} !== {exp_pulse(c, 10, 4, 3, 2), 1'b1} ||
          TRIG_IDX !== DW'(exp_tidx(c, 10, 4))) begin
        errors++;
        $display("FAIL rst_restart c=%0d: got %b idx %0d expected %b idx %0d", c,
                 {TRIG, ACP, ARP, RUNNING}, TRIG_IDX, {exp_pulse(c, 10, 4, 3, 2), 1'b1},
                 exp_tidx(c, 10, 4));
      end
    end
  endtask

  task automatic test_degenerate();
    RST = 1'b1; EN = 1'b0;
    tick();
    RST = 1'b0;
    TRIG_PERIOD = 2; TRIG_PER_ACP = 1; ACP_PER_ARP = 1; PULSE_LEN = 1; EN = 1'b1;
    tick();  // edge k
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({TRIG, ACP, ARP} !== ((c % 2 == 0) ? 3'b111 : 3'b000) ||
          TRIG_IDX !== '0 || ACP_IDX !== '0) begin
        errors++;
        $display("FAIL degenerate c=%0d: got %b idx %0d/%0d expected %b idx 0/0", c,
                 {TRIG, ACP, ARP}, TRIG_IDX, ACP_IDX, (c % 2 == 0) ? 3'b111 : 3'b000);
      end
    end
    EN = 1'b0;
    tick();
    checks++;
    if ({TRIG, ACP, ARP, RUNNING} !== 4'b0000) begin
      errors++; $display("FAIL degenerate_stop: got %b expected 0000", {TRIG, ACP, ARP, RUNNING});
    end
`ifdef RADAR_GEN_REV_CNT_EN
    checks++;
    if (REV_CNT !== DW'(6)) begin
      errors++; $display("FAIL degenerate_rev_cnt: got %0d expected 6", REV_CNT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_start();
    test_stop_at_boundary();
    test_invalid_config();
    test_relatch();
    test_reset_mid_pulse();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radar_signal_gen.md
Name: radar_signal_gen

Overview:
- Synthesises the radar timing triplet for the simulator: TRIG (transmit trigger), ACP (azimuth count pulse) and ARP (azimuth reference pulse, one per revolution).
- Driven from a single system clock. Timing is set by cycle counts on the config ports.
- It is the source side of the radar statistics path. When its outputs feed the statistics block, that block must report these values:
  - TRIG count per ACP = TRIG_PER_ACP.
  - ACP count per ARP = ACP_PER_ARP.
  - Revolution time = TRIG_PERIOD*TRIG_PER_ACP*ACP_PER_ARP clock cycles.

Parameters:
DATA_WIDTH, 32, width of period/count config ports and index outputs
PULSE_BITS, 8, width of pulse-length config port

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
EN  input  1  level: 1 = run / keep running, 0 = stop at next revolution boundary
TRIG_PERIOD  input  DATA_WIDTH  clock cycles between TRIG rising edges
TRIG_PER_ACP  input  DATA_WIDTH  TRIG pulses per ACP interval
ACP_PER_ARP  input  DATA_WIDTH  ACP pulses per revolution
PULSE_LEN  input  PULSE_BITS  high time in cycles of every TRIG/ACP/ARP pulse
TRIG  output  1  trigger pulse, registered
ACP  output  1  azimuth count pulse, registered
ARP  output  1  azimuth reference pulse, registered
RUNNING  output  1  1 while in RUN state
TRIG_IDX  output  DATA_WIDTH  index of current trigger within ACP interval (0..TRIG_PER_ACP-1)
ACP_IDX  output  DATA_WIDTH  index of current ACP within revolution (0..ACP_PER_ARP-1)
CFG_ERR  output  1  sticky: last start or boundary re-latch saw invalid config

Behaviour:
- Reset: RST=1 at a rising edge gives the following one cycle later, overriding all other activity including mid-pulse:
  - State IDLE.
  - All outputs 0: TRIG, ACP, ARP, RUNNING, TRIG_IDX, ACP_IDX, CFG_ERR.
  - Internal counters 0.
- Config validity: all four conditions must hold.
  - TRIG_PERIOD>=2.
  - TRIG_PER_ACP>=1.
  - ACP_PER_ARP>=1.
  - 1<=PULSE_LEN<TRIG_PERIOD, comparing PULSE_LEN zero-extended to DATA_WIDTH.
- Config latching: only at a start or a revolution boundary. Port changes at any other time are ignored.
- IDLE state:
  - Outputs low; RUNNING=0.
  - EN=1 sampled with valid config at edge k: latch config, clear CFG_ERR, enter RUN.
  - At edge k+1: TRIG=ACP=ARP=1, RUNNING=1, TRIG_IDX=0, ACP_IDX=0.
  - EN=1 sampled with invalid config: stay IDLE, set CFG_ERR. It stays 1 until a valid start or RST.
- RUN counters:
  - Period counter pcnt runs 0..TRIG_PERIOD-1 and wraps.
  - The cycle with pcnt==0 is a trigger-start cycle.
  - At each pcnt wrap, TRIG_IDX increments. It wraps at TRIG_PER_ACP-1 to 0, and that wrap increments ACP_IDX.
  - ACP_IDX wraps at ACP_PER_ARP-1 to 0.
- RUN pulses:
  - Trigger-start cycle: TRIG=1.
  - Trigger-start with TRIG_IDX==0: ACP=1 as well.
  - Trigger-start with TRIG_IDX==0 and ACP_IDX==0: ARP=1 as well. That cycle is the revolution boundary.
  - Each asserted output stays high exactly PULSE_LEN cycles, then 0 until its next start. Simultaneous pulses rise and fall on the same edges.
- Revolution boundary, evaluated on the edge where the next ARP would start:
  - EN=0: go IDLE. Outputs stay 0 and RUNNING=0 on that edge. The last revolution is always complete; no truncated revolutions.
  - EN=1, config valid: re-latch config; the new values apply from this ARP.
  - EN=1, config invalid: set CFG_ERR and go IDLE as for EN=0.
- EN dropping mid-revolution has no effect until the boundary.
- Degenerate sizes: TRIG_PER_ACP=1 gives ACP on every TRIG. ACP_PER_ARP=1 gives ARP on every ACP.
- Counter arithmetic: unsigned DATA_WIDTH. Configured maxima of 2^DATA_WIDTH-1 are legal; compare against count-1 without overflow.

Optional Feature:
- Macro: RADAR_GEN_REV_CNT_EN.
- Defined:
  - Adds output port REV_CNT, width DATA_WIDTH.
  - Reset to 0.
  - Increments by 1 at every revolution boundary where RUN continues, and also when RUN exits at a boundary. In both cases it counts completed revolutions.
  - Wraps from 2^DATA_WIDTH-1 to 0.
  - Not cleared by a new start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic start:
  - Stimulus: RST, then TRIG_PERIOD=10, TRIG_PER_ACP=4, ACP_PER_ARP=3, PULSE_LEN=2, EN=1 at edge k.
  - Required: TRIG, ACP, ARP high at edges k+1 and k+2, low at k+3.
  - Required: TRIG every 10 cycles; ACP every 40 cycles; ARP every 120 cycles; TRIG_IDX and ACP_IDX sequence correct.
- Stop at boundary:
  - Stimulus: config as above; drop EN at cycle 55 of a revolution.
  - Required: pulses continue to cycle 119; no ARP at 120; RUNNING=0 from that edge.
  - Required with macro: REV_CNT increments by 1.
- Invalid config:
  - Stimulus: PULSE_LEN=10 with TRIG_PERIOD=10, EN=1.
  - Required: stays IDLE, CFG_ERR=1, no pulses.
  - Then set PULSE_LEN=3: start occurs and CFG_ERR=0.
- Re-latch:
  - Stimulus: change ACP_PER_ARP 3->5 mid-revolution.
  - Required: current revolution has 3 ACPs; next revolution has 5 ACPs (200 cycles).
- Degenerate:
  - Stimulus: TRIG_PERIOD=2, TRIG_PER_ACP=1, ACP_PER_ARP=1, PULSE_LEN=1.
  - Required: TRIG=ACP=ARP toggling 1,0,1,0.
- Reset mid-pulse:
  - Stimulus: assert RST during the second cycle of an ARP pulse.
  - Required: all outputs 0 on the next edge; restart is clean after RST release.
